stack_trail: RTL and testbench

Parametrised LIFO for the SAT solver's assignment trail, successor to the 1-bit boolean stack. Each entry is WIDTH bits wide and carries a decision-mark bit, and the block tracks the current decision level. It supports push, pop, replace-top, and a multi-cycle backtrack that pops entries until the trail returns to a requested decision level. It sits between the decision/propagation logic (pushes) and the conflict handler (backtrack requests).

---
 rtl/stack_trail_if.sv | 36 +++
 rtl/stack_trail.sv | 174 +++++++++++++++++
 tb/tb_stack_trail.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/stack_trail_if.sv
// Request/status bundle between the SAT trail stack and its users.
// Master drives push/pop/backtrack requests; slave (the stack) drives status.
interface stack_trail_if #(
  parameter int WIDTH = 1,
  parameter int LVL_W = 5
);
  logic             wr_en;
  logic             mark;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             bt_en;
  logic [LVL_W-1:0] bt_level;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] front;
  logic             front_mark;
  logic [LVL_W-1:0] count;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             busy;
  logic             bt_done;
  logic             err_ovf;
  logic             err_unf;

  modport master (
    output wr_en, mark, pop, din, bt_en, bt_level,
    input  dout, front, front_mark, count, level, full, empty, busy, bt_done,
           err_ovf, err_unf
  );

  modport slave (
    input  wr_en, mark, pop, din, bt_en, bt_level,
    output dout, front, front_mark, count, level, full, empty, busy, bt_done,
           err_ovf, err_unf
  );
endinterface

// File: rtl/stack_trail.sv
// Assignment-trail LIFO with decision marks, level tracking and multi-cycle backtrack.
// Optional STACK_TRAIL_ERR_EN enables sticky overflow/underflow flags.
module stack_trail #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH+1)
) (
  input  logic           clock,
  input  logic           reset_n,
  stack_trail_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BT   = 1'b1;

  logic [WIDTH:0]   mem_r [DEPTH];
  logic [0:0]       state_r;
  logic [LVL_W-1:0] count_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] bt_target_r;
  logic [WIDTH-1:0] dout_r;
  logic             busy_r;
  logic             bt_done_r;

  logic [AW-1:0]    top_idx_s;
  logic [AW-1:0]    wr_idx_s;
  logic             empty_s;
  logic             full_s;
  logic [WIDTH:0]   top_entry_s;
  logic             top_mark_s;
  logic [WIDTH-1:0] top_data_s;
  logic [LVL_W-1:0] level_dec_s;
  logic             idle_req_s;
  logic             push_s;
  logic             repl_s;
  logic             pop_s;
  logic             mem_we_s;
  logic [AW-1:0]    mem_waddr_s;

  // Top-of-stack view and request decode for the idle state
  always_comb begin
    top_idx_s   = AW'(count_r - LVL_W'(1));
    wr_idx_s    = AW'(count_r);
    empty_s     = (count_r == LVL_W'(0));
    full_s      = (count_r == LVL_W'(DEPTH));
    top_entry_s = empty_s ? '0 : mem_r[top_idx_s];
    top_mark_s  = top_entry_s[WIDTH];
    top_data_s  = top_entry_s[WIDTH-1:0];
    level_dec_s = level_r - LVL_W'(top_mark_s);
    idle_req_s  = (state_r == ST_IDLE) && !bus.bt_en;
    push_s      = 1'b0;
    repl_s      = 1'b0;
    pop_s       = 1'b0;
    if (idle_req_s) begin
      // wr_en & pop on an empty stack falls through to a plain push
      if (bus.wr_en && bus.pop && !empty_s) begin
        repl_s = 1'b1;
      end else if (bus.wr_en && !full_s) begin
        push_s = 1'b1;
      end else if (bus.pop && !bus.wr_en && !empty_s) begin
        pop_s = 1'b1;
      end else begin
        push_s = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
    mem_we_s    = push_s || repl_s;
    mem_waddr_s = repl_s ? top_idx_s : wr_idx_s;
  end

  // Entry storage; contents are left untouched by reset
  always_ff @(posedge clock) begin
    if (reset_n && mem_we_s) begin
      mem_r[mem_waddr_s] <= {bus.mark, bus.din};
    end
  end

  // Control FSM, occupancy/level counters and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      level_r     <= '0;
      bt_target_r <= '0;
      dout_r      <= '0;
      busy_r      <= 1'b0;
      bt_done_r   <= 1'b0;
    end else begin
      bt_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.bt_en) begin
            if (bus.bt_level >= level_r) begin
              bt_done_r <= 1'b1;
            end else begin
              bt_target_r <= bus.bt_level;
              busy_r      <= 1'b1;
              state_r     <= ST_BT;
            end
          end else if (repl_s) begin
            dout_r  <= top_data_s;
            level_r <= level_dec_s + LVL_W'(bus.mark);
          end else if (push_s) begin
            count_r <= count_r + LVL_W'(1);
            level_r <= level_r + LVL_W'(bus.mark);
          end else if (pop_s) begin
            dout_r  <= top_data_s;
            count_r <= count_r - LVL_W'(1);
            level_r <= level_dec_s;
          end
        end
        ST_BT: begin
          // Empty here means the trail is already drained; bail out cleanly
          if (empty_s) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            bt_done_r <= 1'b1;
          end else begin
            dout_r  <= top_data_s;
            count_r <= count_r - LVL_W'(1);
            level_r <= level_dec_s;
            if (top_mark_s && (level_dec_s == bt_target_r)) begin
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
              bt_done_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_TRAIL_ERR_EN
  logic err_ovf_r;
  logic err_unf_r;
  logic ovf_s;
  logic unf_s;

  assign ovf_s = idle_req_s && bus.wr_en && !bus.pop && full_s;
  assign unf_s = idle_req_s && bus.pop && !bus.wr_en && empty_s;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      err_ovf_r <= err_ovf_r || ovf_s;
      err_unf_r <= err_unf_r || unf_s;
    end
  end

  assign bus.err_ovf = err_ovf_r;
  assign bus.err_unf = err_unf_r;
`else
  assign bus.err_ovf = 1'b0;
  assign bus.err_unf = 1'b0;
`endif

  assign bus.dout       = dout_r;
  assign bus.front      = top_data_s;
  assign bus.front_mark = top_mark_s;
  assign bus.count      = count_r;
  assign bus.level      = level_r;
  assign bus.full       = full_s;
  assign bus.empty      = empty_s;
  assign bus.busy       = busy_r;
  assign bus.bt_done    = bt_done_r;
endmodule

// File: tb/tb_stack_trail.sv
// Directed bench for stack_trail: a 1-bit/4-deep instance and an 8-bit/16-deep instance.
module tb_stack_trail;
  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef STACK_TRAIL_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clock = ~clock;

  stack_trail_if #(.WIDTH(1), .LVL_W(3)) b1 ();
  stack_trail_if #(.WIDTH(8), .LVL_W(5)) b8 ();

  stack_trail #(.WIDTH(1), .DEPTH(4))  u1 (.clock(clock), .reset_n(reset_n), .bus(b1));
  stack_trail #(.WIDTH(8), .DEPTH(16)) u8 (.clock(clock), .reset_n(reset_n), .bus(b8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push1(input logic d);
    b1.wr_en = 1'b1; b1.din = d; b1.mark = 1'b0;
    tick();
    b1.wr_en = 1'b0;
  endtask

  task automatic pop1();
    b1.pop = 1'b1;
    tick();
    b1.pop = 1'b0;
  endtask

  task automatic push8(input logic [7:0] d, input logic m);
    b8.wr_en = 1'b1; b8.din = d; b8.mark = m;
    tick();
    b8.wr_en = 1'b0; b8.mark = 1'b0;
  endtask

  task automatic bt8(input logic [4:0] lvl);
    b8.bt_en = 1'b1; b8.bt_level = lvl;
    tick();
    b8.bt_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    b1.wr_en = 1'b0; b1.mark = 1'b0; b1.pop = 1'b0; b1.din = 1'b0;
    b1.bt_en = 1'b0; b1.bt_level = 3'd0;
    b8.wr_en = 1'b0; b8.mark = 1'b0; b8.pop = 1'b0; b8.din = 8'h00;
    b8.bt_en = 1'b0; b8.bt_level = 5'd0;
    tick();
    tick();
    reset_n = 1'b1;

    chk("rst_count",   32'(b1.count), 32'd0);
    chk("rst_level",   32'(b1.level), 32'd0);
    chk("rst_empty",   32'(b1.empty), 32'd1);
    chk("rst_full",    32'(b1.full),  32'd0);
    chk("rst_front",   32'(b1.front), 32'd0);
    chk("rst_dout",    32'(b8.dout),  32'd0);
    chk("rst_busy",    32'(b8.busy),  32'd0);
    chk("rst_done",    32'(b8.bt_done), 32'd0);
    chk("rst_fmark",   32'(b8.front_mark), 32'd0);
    chk("rst_ovf",     32'(b1.err_ovf), 32'd0);

    // Fill the 4-deep stack, then overflow
    push1(1'b1); push1(1'b0); push1(1'b1); push1(1'b0);
    chk("fill_count",  32'(b1.count), 32'd4);
    chk("fill_full",   32'(b1.full),  32'd1);
    chk("fill_front",  32'(b1.front), 32'd0);
    push1(1'b1);
    chk("ovf_count",   32'(b1.count), 32'd4);
    chk("ovf_flag",    32'(b1.err_ovf), 32'(ERR_EXP));
    chk("ovf_front",   32'(b1.front), 32'd0);

    pop1(); chk("pop1_dout", 32'(b1.dout), 32'd0);
    pop1(); chk("pop2_dout", 32'(b1.dout), 32'd1);
    pop1(); chk("pop3_dout", 32'(b1.dout), 32'd0);
    pop1(); chk("pop4_dout", 32'(b1.dout), 32'd1);
    chk("pop_empty",   32'(b1.empty), 32'd1);
    chk("pop_unf_pre", 32'(b1.err_unf), 32'd0);
    pop1();
    chk("unf_flag",    32'(b1.err_unf), 32'(ERR_EXP));
    chk("unf_dout",    32'(b1.dout), 32'd1);
    chk("unf_count",   32'(b1.count), 32'd0);

    // Replace on a full stack
    push1(1'b1); push1(1'b0); push1(1'b1); push1(1'b0);
    b1.wr_en = 1'b1; b1.pop = 1'b1; b1.din = 1'b1;
    tick();
    b1.wr_en = 1'b0; b1.pop = 1'b0;
    chk("repl_dout",   32'(b1.dout),  32'd0);
    chk("repl_front",  32'(b1.front), 32'd1);
    chk("repl_count",  32'(b1.count), 32'd4);

    // 8-bit trail with two decision levels
    push8(8'hA0, 1'b0); push8(8'hB1, 1'b1); push8(8'hC2, 1'b0);
    push8(8'hD3, 1'b1); push8(8'hE4, 1'b0);
    chk("t8_level",    32'(b8.level), 32'd2);
    chk("t8_count",    32'(b8.count), 32'd5);
    chk("t8_front",    32'(b8.front), 32'hE4);

    bt8(5'd1);
    chk("bt1_busy0",   32'(b8.busy), 32'd1);
    chk("bt1_done0",   32'(b8.bt_done), 32'd0);
    tick();
    chk("bt1_dout0",   32'(b8.dout), 32'hE4);
    chk("bt1_busy1",   32'(b8.busy), 32'd1);
    tick();
    chk("bt1_dout1",   32'(b8.dout), 32'hD3);
    chk("bt1_busy2",   32'(b8.busy), 32'd0);
    chk("bt1_done",    32'(b8.bt_done), 32'd1);
    chk("bt1_level",   32'(b8.level), 32'd1);
    chk("bt1_count",   32'(b8.count), 32'd3);
    chk("bt1_front",   32'(b8.front), 32'hC2);

    // Push accepted in the bt_done cycle restores the same trail
    push8(8'hD3, 1'b1);
    chk("bt1_doneoff", 32'(b8.bt_done), 32'd0);
    push8(8'hE4, 1'b0);
    chk("re_count",    32'(b8.count), 32'd5);

    bt8(5'd0);
    b8.wr_en = 1'b1; b8.din = 8'hFF;
    chk("bt0_busy0",   32'(b8.busy), 32'd1);
    tick(); chk("bt0_dout0", 32'(b8.dout), 32'hE4);
    tick(); chk("bt0_dout1", 32'(b8.dout), 32'hD3);
    tick(); chk("bt0_dout2", 32'(b8.dout), 32'hC2);
    chk("bt0_busy3",   32'(b8.busy), 32'd1);
    tick();
    b8.wr_en = 1'b0;
    chk("bt0_dout3",   32'(b8.dout), 32'hB1);
    chk("bt0_busy4",   32'(b8.busy), 32'd0);
    chk("bt0_done",    32'(b8.bt_done), 32'd1);
    chk("bt0_count",   32'(b8.count), 32'd1);
    chk("bt0_level",   32'(b8.level), 32'd0);
    chk("bt0_front",   32'(b8.front), 32'hA0);
    chk("bt0_ovf",     32'(b8.err_ovf), 32'd0);

    // Backtrack target at or above current level
    push8(8'hB1, 1'b1); push8(8'hC2, 1'b0); push8(8'hD3, 1'b1);
    chk("hi_level",    32'(b8.level), 32'd2);
    bt8(5'd3);
    chk("hi_done",     32'(b8.bt_done), 32'd1);
    chk("hi_busy",     32'(b8.busy), 32'd0);
    chk("hi_count",    32'(b8.count), 32'd4);
    bt8(5'd2);
    chk("eq_done",     32'(b8.bt_done), 32'd1);
    chk("eq_count",    32'(b8.count), 32'd4);
    tick();
    chk("eq_doneoff",  32'(b8.bt_done), 32'd0);

    // Reset during the second backtrack cycle
    bt8(5'd0);
    chk("rb_busy0",    32'(b8.busy), 32'd1);
    tick();
    chk("rb_busy1",    32'(b8.busy), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rb_busy",     32'(b8.busy), 32'd0);
    chk("rb_done",     32'(b8.bt_done), 32'd0);
    chk("rb_count",    32'(b8.count), 32'd0);
    chk("rb_empty",    32'(b8.empty), 32'd1);
    chk("rb_level",    32'(b8.level), 32'd0);
    tick();
    chk("rb_stay",     32'(b8.busy), 32'd0);

    // wr_en & pop on empty acts as a push
    b1.wr_en = 1'b1; b1.pop = 1'b1; b1.din = 1'b1;
    tick();
    b1.wr_en = 1'b0; b1.pop = 1'b0;
    chk("wpe_count",   32'(b1.count), 32'd1);
    chk("wpe_front",   32'(b1.front), 32'd1);
    chk("wpe_dout",    32'(b1.dout),  32'd0);
    chk("wpe_unf",     32'(b1.err_unf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
